seven_segment_reader: RTL and testbench

Receive-side counterpart of the seg7 display path. It samples a 7-segment pattern, filters glitches and decodes the pattern back to a BCD digit. It counts accepted digits and illegal patterns. It sits on the input pins of a checker tile that verifies a display-driving tile, or on a looped-back display bus during bring-up.

---
 rtl/seven_segment_reader.sv | 114 +++++++++++
 tb/tb_seven_segment_reader.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_reader.sv
// Samples an asynchronous 7-segment bus, debounces it, and decodes accepted
// patterns back to BCD while counting legal digits and illegal patterns.
module seven_segment_reader #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg_in,
  output logic [3:0] digit,
  output logic       new_digit,
  output logic       pattern_error,
  output logic       blank,
  output logic [7:0] digit_count,
  output logic [7:0] error_count
);

  localparam logic [7:0] STABLE_LIMIT = 8'(STABLE_CYCLES);

  // Segment patterns for digits 9..0, digit 0 in the low seven bits.
  localparam logic [69:0] DIGIT_PATTERNS = {
    7'b1100111, 7'b1111111, 7'b0000111, 7'b1111100, 7'b1101101,
    7'b1100110, 7'b1001111, 7'b1011011, 7'b0000110, 7'b0111111
  };

  typedef enum logic {EMPTY, TRACKING} state_t;

  state_t      state_reg, state_next;
  logic [6:0]  s1_reg, s2_reg, cand_reg, acc_reg;
  logic [7:0]  cnt_reg;
  logic [9:0]  match;
  logic [3:0]  dec_value;
  logic        dec_legal;
  logic        qualified;
  logic        accept;

  genvar gi;
  generate
    for (gi = 0; gi < 10; gi++) begin : g_match
      assign match[gi] = (s2_reg == DIGIT_PATTERNS[gi*7 +: 7]);
    end
  endgenerate

  always_comb begin
    dec_value = '0;
    for (int i = 0; i < 10; i++) begin
      if (match[i]) dec_value = 4'(i);
    end
    dec_legal = |match;
  end

  // Qualification happens on the edge where the counter reaches the limit,
  // including the restart edge itself when the limit is one.
  assign qualified = (s2_reg != cand_reg) ? (STABLE_LIMIT == 8'd1)
                                          : (cnt_reg + 8'd1 == STABLE_LIMIT);

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    if (qualified && (state_reg == EMPTY || s2_reg != acc_reg)) begin
      accept     = 1'b1;
      state_next = TRACKING;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= EMPTY;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_reg        <= '0;
      s2_reg        <= '0;
      cand_reg      <= '0;
      cnt_reg       <= '0;
      acc_reg       <= '0;
      digit         <= '0;
      new_digit     <= 1'b0;
      pattern_error <= 1'b0;
      blank         <= 1'b0;
      digit_count   <= '0;
      error_count   <= '0;
    end else begin
      s1_reg <= seg_in;
      s2_reg <= s1_reg;

      if (s2_reg != cand_reg) begin
        cand_reg <= s2_reg;
        cnt_reg  <= 8'd1;
      end else if (cnt_reg < STABLE_LIMIT) begin
        cnt_reg <= cnt_reg + 8'd1;
      end

      new_digit     <= 1'b0;
      pattern_error <= 1'b0;
      if (accept) begin
        acc_reg <= s2_reg;
        if (dec_legal) begin
          digit       <= dec_value;
          new_digit   <= 1'b1;
          digit_count <= digit_count + 8'd1;
          blank       <= 1'b0;
        end else if (s2_reg == 7'b0000000) begin
          blank <= 1'b1;
        end else begin
          pattern_error <= 1'b1;
          if (error_count != 8'hFF) error_count <= error_count + 8'd1;
          blank <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_reader.sv
// Scoreboard bench: stimulus pushes expected pulses, a negedge monitor pops
// and compares them whenever new_digit or pattern_error is seen.
module tb_seven_segment_reader;

  localparam int STABLE = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] seg_in;
  logic [3:0] digit;
  logic       new_digit;
  logic       pattern_error;
  logic       blank;
  logic [7:0] digit_count;
  logic [7:0] error_count;

  seven_segment_reader #(.STABLE_CYCLES(STABLE)) dut (
    .clk(clk),
    .reset(reset),
    .seg_in(seg_in),
    .digit(digit),
    .new_digit(new_digit),
    .pattern_error(pattern_error),
    .blank(blank),
    .digit_count(digit_count),
    .error_count(error_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    logic [3:0] digit;
    logic [7:0] dcount;
    logic [7:0] ecount;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  logic [3:0] exp_digit  = '0;
  logic [7:0] exp_dcount = '0;
  logic [7:0] exp_ecount = '0;

  always @(negedge clk) begin
    if (new_digit && pattern_error) begin
      checks++;
      errors++;
      $display("FAIL exclusive: new_digit and pattern_error both high at cycle %0d", cyc);
    end
    if (new_digit || pattern_error) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: cycle %0d new_digit=%0b pattern_error=%0b digit=%0d",
                 cyc, new_digit, pattern_error, digit);
      end else begin
        mon_e = sb_q.pop_front();
        if (pattern_error !== mon_e.is_err || new_digit !== !mon_e.is_err ||
            digit !== mon_e.digit || digit_count !== mon_e.dcount ||
            error_count !== mon_e.ecount || cyc != mon_e.cyc) begin
          errors++;
          $display("FAIL pulse: got err=%0b digit=%0d dcnt=%0d ecnt=%0d cyc=%0d, want err=%0b digit=%0d dcnt=%0d ecnt=%0d cyc=%0d",
                   pattern_error, digit, digit_count, error_count, cyc,
                   mon_e.is_err, mon_e.digit, mon_e.dcount, mon_e.ecount, mon_e.cyc);
        end else begin
          $display("txn cyc=%0d %s digit=%0d dcnt=%0d ecnt=%0d", cyc,
                   mon_e.is_err ? "error" : "digit", digit, digit_count, error_count);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // kind: 0 = no pulse expected, 1 = legal digit d, 2 = illegal pattern.
  // Called at a negedge; the pulse is expected STABLE+2 cycle counts later.
  task automatic drive(input logic [6:0] p, input int hold, input int kind, input logic [3:0] d);
    exp_t e;
    seg_in = p;
    if (kind == 1) begin
      exp_dcount = exp_dcount + 8'd1;
      exp_digit  = d;
      e = '{1'b0, d, exp_dcount, exp_ecount, cyc + STABLE + 2};
      sb_q.push_back(e);
    end else if (kind == 2) begin
      if (exp_ecount != 8'hFF) exp_ecount = exp_ecount + 8'd1;
      e = '{1'b1, exp_digit, exp_dcount, exp_ecount, cyc + STABLE + 2};
      sb_q.push_back(e);
    end
    repeat (hold) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_digit"}, 32'(digit), 32'd0);
    check({tag, "_new_digit"}, 32'(new_digit), 32'd0);
    check({tag, "_pattern_error"}, 32'(pattern_error), 32'd0);
    check({tag, "_blank"}, 32'(blank), 32'd0);
    check({tag, "_digit_count"}, 32'(digit_count), 32'd0);
    check({tag, "_error_count"}, 32'(error_count), 32'd0);
  endtask

  initial begin
    reset  = 1'b0;
    seg_in = 7'b0111111;
    #1;
    check_zero("reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // First digit after reset, then two more legal digits.
    drive(7'b0111111, 10, 1, 4'd0);
    check("first_digit", 32'(digit), 32'd0);
    check("first_count", 32'(digit_count), 32'd1);
    drive(7'b1111111, 10, 1, 4'd8);
    drive(7'b1100111, 10, 1, 4'd9);
    check("seq_count", 32'(digit_count), 32'd3);

    // Illegal patterns, then alternation until the error counter saturates.
    drive(7'b1000000, 10, 2, 4'd0);
    check("err_count_1", 32'(error_count), 32'd1);
    for (int i = 0; i < 300; i++)
      drive((i % 2 == 0) ? 7'b0000001 : 7'b1000000, 10, 2, 4'd0);
    check("err_saturated", 32'(error_count), 32'd255);
    check("err_digit_held", 32'(digit), 32'd9);

    // Short glitch is filtered; a glitch of STABLE samples is accepted.
    drive(7'b0000110, 10, 1, 4'd1);
    drive(7'b1011011, 3, 0, 4'd0);
    drive(7'b0000110, 10, 0, 4'd0);
    check("short_glitch_digit", 32'(digit), 32'd1);
    drive(7'b1011011, 4, 1, 4'd2);
    drive(7'b0000110, 10, 1, 4'd1);
    check("long_glitch_digit", 32'(digit), 32'd1);

    // Blank pattern sets the level without a pulse; a digit clears it.
    drive(7'b0000000, 10, 0, 4'd0);
    check("blank_set", 32'(blank), 32'd1);
    check("blank_digit_held", 32'(digit), 32'd1);
    drive(7'b1001111, 10, 1, 4'd3);
    check("blank_clear", 32'(blank), 32'd0);
    check("blank_then_digit", 32'(digit), 32'd3);

    // Asynchronous reset between edges while a new pattern is mid-filter.
    drive(7'b1101101, 2, 0, 4'd0);
    #2 reset = 1'b0;
    #1;
    check_zero("async_reset");
    repeat (3) @(negedge clk);
    exp_digit  = '0;
    exp_dcount = '0;
    exp_ecount = '0;
    reset = 1'b1;
    drive(7'b1101101, 10, 1, 4'd5);
    check("rereport_digit", 32'(digit), 32'd5);
    check("rereport_count", 32'(digit_count), 32'd1);

    // 255 further legal transitions wrap the digit counter to zero.
    for (int i = 0; i < 255; i++) begin
      if (i % 2 == 0) drive(7'b1111111, 8, 1, 4'd8);
      else            drive(7'b0000110, 8, 1, 4'd1);
    end
    check("count_wrap", 32'(digit_count), 32'd0);
    check("wrap_digit", 32'(digit), 32'd8);

    repeat (10) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
